// File: rtl/huff_pkg.sv
// Shared types and helpers for the Huffman bitstream decoder.
// Holds the decoder state encoding, table size and mask popcount helper.
package huff_pkg;

  typedef enum logic [1:0] {SHIFT, EMIT, DONE, ERR} dec_state_t;

  localparam int unsigned NUM_SYM    = 6;
  localparam int unsigned CODE_W_DEF = 8;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      n += {31'b0, v[0]};
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/huff_code_match.sv
// Combinational codeword matcher: compares the freshly shifted bits against
// the six HC/M table entries; lowest matching index wins.
module huff_code_match
  import huff_pkg::*;
#(
  parameter int unsigned CODE_W = CODE_W_DEF,
  parameter int unsigned LEN_W  = $clog2(CODE_W + 1)
) (
  input  logic [CODE_W-1:0]              shreg_new,
  input  logic [LEN_W-1:0]               len_new,
  input  logic [NUM_SYM-1:0][CODE_W-1:0] hc,
  input  logic [NUM_SYM-1:0][CODE_W-1:0] m,
  output logic                           hit,
  output logic [2:0]                     hit_idx
);

  logic [NUM_SYM-1:0]      match;
  logic [NUM_SYM:0][2:0]   idx_chain;

  assign idx_chain[NUM_SYM] = '0;

  // A zero-length mask can never equal a non-zero length, so it never hits.
  for (genvar k = 0; k < NUM_SYM; k++) begin : g_ent
    assign match[k] = (len_new != '0) &&
                      (popcount(32'(m[k])) == 32'(len_new)) &&
                      ((shreg_new & m[k]) == (hc[k] & m[k]));
    assign idx_chain[k] = match[k] ? 3'(k + 1) : idx_chain[k + 1];
  end

  assign hit     = |match;
  assign hit_idx = idx_chain[0];

endmodule

// File: rtl/huff_decoder.sv
// Huffman bitstream decoder: serial code bits in, gray symbols 1..6 out.
// Optional HUFF_DEC_HIST_CHECK_EN adds per-symbol histogram check vs EXP1..EXP6.
module huff_decoder
  import huff_pkg::*;
#(
  parameter int unsigned NUM_SYMBOLS = 100,
  parameter int unsigned CODE_W      = CODE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_data,
  output logic              bit_ready,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
`ifdef HUFF_DEC_HIST_CHECK_EN
  input  logic [7:0]        EXP1,
  input  logic [7:0]        EXP2,
  input  logic [7:0]        EXP3,
  input  logic [7:0]        EXP4,
  input  logic [7:0]        EXP5,
  input  logic [7:0]        EXP6,
  output logic              hist_err,
`endif
  output logic              gray_valid,
  output logic [7:0]        gray_data,
  input  logic              gray_ready,
  output logic              dec_end,
  output logic              dec_err
);

  localparam int unsigned LEN_W = $clog2(CODE_W + 1);

  dec_state_t state, state_nxt;

  // The MSB of the shift register is always shifted out before it is read,
  // so only CODE_W-1 bits are stored; the matcher sees the full CODE_W bits.
  logic [CODE_W-2:0]             shreg;
  logic [CODE_W-1:0]             shreg_new;
  logic [LEN_W-1:0]              len, len_new;
  logic [7:0]                    sym_cnt;
  logic                          hit, bit_xfer, gray_xfer, last_sym;
  logic [2:0]                    hit_idx;
  logic [NUM_SYM-1:0][CODE_W-1:0] hc_tab, m_tab;

  assign hc_tab = {HC6, HC5, HC4, HC3, HC2, HC1};
  assign m_tab  = {M6, M5, M4, M3, M2, M1};

  assign shreg_new = {shreg, bit_data};
  assign len_new   = len + LEN_W'(1);
  assign bit_xfer  = bit_valid && (state == SHIFT);
  assign gray_xfer = gray_ready && (state == EMIT);
  assign last_sym  = (sym_cnt + 8'd1) == 8'(NUM_SYMBOLS);

  assign bit_ready  = reset && (state == SHIFT);
  assign gray_valid = (state == EMIT);
  assign dec_end    = (state == DONE);
  assign dec_err    = (state == ERR);

  huff_code_match #(
    .CODE_W (CODE_W),
    .LEN_W  (LEN_W)
  ) u_match (
    .shreg_new (shreg_new),
    .len_new   (len_new),
    .hc        (hc_tab),
    .m         (m_tab),
    .hit       (hit),
    .hit_idx   (hit_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SHIFT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SHIFT: begin
        if (bit_xfer) begin
          if (hit)                             state_nxt = EMIT;
          else if (len_new == LEN_W'(CODE_W))  state_nxt = ERR;
        end
      end
      EMIT: begin
        if (gray_xfer) state_nxt = last_sym ? DONE : SHIFT;
      end
      DONE:    state_nxt = DONE;
      ERR:     state_nxt = ERR;
      default: state_nxt = SHIFT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      len       <= '0;
      sym_cnt   <= '0;
      gray_data <= '0;
    end else begin
      if (bit_xfer) begin
        if (hit) begin
          shreg     <= '0;
          len       <= '0;
          gray_data <= {5'b0, hit_idx};
        end else begin
          shreg <= shreg_new[CODE_W-2:0];
          len   <= len_new;
        end
      end
      if (gray_xfer) sym_cnt <= sym_cnt + 8'd1;
    end
  end

`ifdef HUFF_DEC_HIST_CHECK_EN
  logic [NUM_SYM-1:0][7:0] exp_tab, hist_cnt, hist_nxt;
  logic [NUM_SYM-1:0]      hist_sel, hist_ne;

  assign exp_tab = {EXP6, EXP5, EXP4, EXP3, EXP2, EXP1};

  // Compare against the post-increment counts so the final symbol is included.
  for (genvar k = 0; k < NUM_SYM; k++) begin : g_hist
    assign hist_sel[k] = gray_xfer && (gray_data == 8'(k + 1));
    assign hist_nxt[k] = hist_cnt[k] + {7'b0, hist_sel[k]};
    assign hist_ne[k]  = (hist_nxt[k] != exp_tab[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_cnt <= '0;
      hist_err <= 1'b0;
    end else begin
      hist_cnt <= hist_nxt;
      if (gray_xfer && last_sym && (|hist_ne)) hist_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_huff_decoder.sv
// Self-checking bench for huff_decoder: directed steps plus randomized frames
// checked against a queue-based reference decoder.
module tb_huff_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_valid, bit_data, bit_ready;
  logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0] M1, M2, M3, M4, M5, M6;
  logic       gray_valid, gray_ready, dec_end, dec_err;
  logic [7:0] gray_data;
`ifdef HUFF_DEC_HIST_CHECK_EN
  logic [7:0] EXP1, EXP2, EXP3, EXP4, EXP5, EXP6;
  logic       hist_err;
`endif

  int checks   = 0;
  int failures = 0;

  int code_val[6] = '{1, 0, 3, 4, 11, 10};
  int code_len[6] = '{1, 2, 3, 4, 5, 5};
  int mask_val[6] = '{1, 3, 7, 15, 31, 31};

  huff_decoder #(.NUM_SYMBOLS(100), .CODE_W(8)) dut (
    .clk(clk), .reset(reset),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
`ifdef HUFF_DEC_HIST_CHECK_EN
    .EXP1(EXP1), .EXP2(EXP2), .EXP3(EXP3), .EXP4(EXP4), .EXP5(EXP5), .EXP6(EXP6),
    .hist_err(hist_err),
`endif
    .gray_valid(gray_valid), .gray_data(gray_data), .gray_ready(gray_ready),
    .dec_end(dec_end), .dec_err(dec_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    HC1 = 8'(code_val[0]); HC2 = 8'(code_val[1]); HC3 = 8'(code_val[2]);
    HC4 = 8'(code_val[3]); HC5 = 8'(code_val[4]); HC6 = 8'(code_val[5]);
    M1 = 8'(mask_val[0]); M2 = 8'(mask_val[1]); M3 = 8'(mask_val[2]);
    M4 = 8'(mask_val[3]); M5 = 8'(mask_val[4]); M6 = 8'(mask_val[5]);
  endtask

  task automatic do_reset();
    bit_valid = 1'b0; gray_ready = 1'b0; bit_data = 1'b0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic send_bit(input int b);
    int w;
    w = 0;
    bit_valid = 1'b1;
    bit_data  = b[0];
    while (!bit_ready && w < 50) begin tick(); w++; end
    if (!bit_ready) chk("send_bit_wait", {31'b0, bit_ready}, 1);
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic recv_sym(output int v);
    int w;
    w = 0;
    while (!gray_valid && w < 50) begin tick(); w++; end
    if (!gray_valid) chk("recv_sym_wait", {31'b0, gray_valid}, 1);
    v = int'(gray_data);
    gray_ready = 1'b1;
    tick();
    gray_ready = 1'b0;
  endtask

  // Reference: walk the bit queue, emit the lowest table entry whose code equals
  // the bits collected since the last symbol; give up after 8 unmatched bits.
  function automatic void model_decode(input int bq[$], input int hv[6], input int mv[6],
                                       output int sq[$], output int err_at);
    int acc, n, k_hit;
    acc = 0; n = 0; err_at = -1;
    sq = {};
    foreach (bq[i]) begin
      acc = ((acc << 1) | bq[i]) & 255;
      n++;
      k_hit = 0;
      for (int k = 6; k >= 1; k--)
        if ($countones(mv[k-1]) == n && (acc & mv[k-1]) == (hv[k-1] & mv[k-1])) k_hit = k;
      if (k_hit != 0) begin
        sq.push_back(k_hit);
        acc = 0; n = 0;
      end else if (n == 8) begin
        err_at = i;
        return;
      end
    end
  endfunction

  task automatic run_frame(input int force_first, input int exp_delta);
    int syms[$], bits[$], exp_q[$];
    int hist[6];
    int err_at, bi, nrx, cyc, s, e;
    bi = 0; nrx = 0; cyc = 0;
    foreach (hist[i]) hist[i] = 0;
    for (int i = 0; i < 100; i++) begin
      s = (i == 0 && force_first != 0) ? 1 : int'($urandom_range(6, 1));
      syms.push_back(s);
      hist[s-1]++;
      for (int b = code_len[s-1] - 1; b >= 0; b--) bits.push_back((code_val[s-1] >> b) & 1);
    end
    model_decode(bits, code_val, mask_val, exp_q, err_at);
`ifdef HUFF_DEC_HIST_CHECK_EN
    EXP1 = 8'(hist[0] + exp_delta); EXP2 = 8'(hist[1]); EXP3 = 8'(hist[2]);
    EXP4 = 8'(hist[3]); EXP5 = 8'(hist[4]); EXP6 = 8'(hist[5]);
`endif
    while (nrx < 100 && cyc < 20000) begin
      bit_valid  = (bi < bits.size()) && ($urandom_range(3, 0) != 0);
      bit_data   = bit_valid ? bits[bi][0] : 1'($urandom_range(1, 0));
      gray_ready = ($urandom_range(3, 0) != 0);
      if (bit_valid && bit_ready) bi++;
      if (gray_valid && gray_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("frame_sym", {24'b0, gray_data}, e);
        if (nrx == 0 && force_first != 0) chk("first_sym_after_reset", {24'b0, gray_data}, 1);
        if (nrx == 99) begin
          chk("dec_end_before_last", {31'b0, dec_end}, 0);
`ifdef HUFF_DEC_HIST_CHECK_EN
          chk("hist_err_before_last", {31'b0, hist_err}, 0);
`endif
        end
        nrx++;
      end
      tick();
      cyc++;
    end
    bit_valid = 1'b0; gray_ready = 1'b0;
    chk("frame_count", nrx, 100);
    chk("bits_consumed", bi, bits.size());
    chk("frame_dec_end", {31'b0, dec_end}, 1);
    chk("frame_gray_valid_done", {31'b0, gray_valid}, 0);
    chk("frame_bit_ready_done", {31'b0, bit_ready}, 0);
    chk("frame_dec_err", {31'b0, dec_err}, 0);
`ifdef HUFF_DEC_HIST_CHECK_EN
    chk("hist_err_with_end", {31'b0, hist_err}, (exp_delta != 0) ? 1 : 0);
`endif
    bit_valid = 1'b1; bit_data = 1'b1;
    repeat (3) tick();
    bit_valid = 1'b0;
    chk("done_bit_ready", {31'b0, bit_ready}, 0);
    chk("done_sticky", {31'b0, dec_end}, 1);
    chk("done_gray_valid", {31'b0, gray_valid}, 0);
  endtask

  initial begin
    int v;
    int bad_bits[$];
    int bad_syms[$];
    int bad_err;

    reset = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; gray_ready = 1'b0;
    load_table();
`ifdef HUFF_DEC_HIST_CHECK_EN
    EXP1 = '0; EXP2 = '0; EXP3 = '0; EXP4 = '0; EXP5 = '0; EXP6 = '0;
`endif
    repeat (3) tick();
    chk("rst_bit_ready", {31'b0, bit_ready}, 0);
    chk("rst_gray_valid", {31'b0, gray_valid}, 0);
    chk("rst_gray_data", {24'b0, gray_data}, 0);
    chk("rst_dec_end", {31'b0, dec_end}, 0);
    chk("rst_dec_err", {31'b0, dec_err}, 0);
`ifdef HUFF_DEC_HIST_CHECK_EN
    chk("rst_hist_err", {31'b0, hist_err}, 0);
`endif
    reset = 1'b1;
    #1;
    chk("rel_bit_ready", {31'b0, bit_ready}, 1);

    // Single-bit codeword, one cycle latency.
    send_bit(1);
    chk("sym1_valid", {31'b0, gray_valid}, 1);
    chk("sym1_data", {24'b0, gray_data}, 1);
    chk("sym1_no_bit", {31'b0, bit_ready}, 0);
    recv_sym(v);
    chk("after_sym1_valid", {31'b0, gray_valid}, 0);
    chk("after_sym1_ready", {31'b0, bit_ready}, 1);

    // Five-bit codeword 01011.
    send_bit(0); send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    chk("sym5_valid", {31'b0, gray_valid}, 1);
    chk("sym5_data", {24'b0, gray_data}, 5);

    // Backpressure: offered 0 bits must not be taken while the symbol waits.
    bit_valid = 1'b1; bit_data = 1'b0; gray_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'b0, gray_valid}, 1);
      chk("bp_data", {24'b0, gray_data}, 5);
      chk("bp_bit_ready", {31'b0, bit_ready}, 0);
    end
    bit_valid = 1'b0;
    recv_sym(v);
    send_bit(1);
    chk("bp_not_consumed_valid", {31'b0, gray_valid}, 1);
    chk("bp_not_consumed_data", {24'b0, gray_data}, 1);
    recv_sym(v);

    // Full randomized frame with exact histogram.
    do_reset();
    run_frame(0, 0);

    // Non-decodable stream with M6 cleared.
    do_reset();
    M6 = 8'h00;
    bad_bits = '{0, 1, 0, 1, 0, 0, 0, 0};
    model_decode(bad_bits, code_val, '{1, 3, 7, 15, 31, 0}, bad_syms, bad_err);
    foreach (bad_bits[i]) begin
      send_bit(bad_bits[i]);
      chk("bad_dec_err", {31'b0, dec_err}, (bad_err >= 0 && i >= bad_err) ? 1 : 0);
      chk("bad_gray_valid", {31'b0, gray_valid}, 0);
    end
    chk("bad_bit_ready", {31'b0, bit_ready}, 0);
    chk("bad_dec_end", {31'b0, dec_end}, 0);
    bit_valid = 1'b1;
    repeat (3) tick();
    bit_valid = 1'b0;
    chk("bad_err_sticky", {31'b0, dec_err}, 1);
    load_table();

    // Reset in the middle of a codeword, then a frame with EXP1 off by one.
    do_reset();
    send_bit(0); send_bit(1);
    reset = 1'b0;
    tick();
    chk("midrst_gray_valid", {31'b0, gray_valid}, 0);
    chk("midrst_bit_ready", {31'b0, bit_ready}, 0);
    reset = 1'b1;
    #1;
    run_frame(1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
